// File: rtl/fsm_transition_monitor.sv
// fsm_transition_monitor
// Passive observer for a small control FSM. Each cycle it samples the observed
// state and output. When the state changes it queues a transition record
// (from, to, out, timestamp) in a small FIFO. It also keeps sticky statistics:
// the set of states visited, whether an illegal encoding appeared, and whether
// a record was lost to a full FIFO. A downstream collector drains the records
// over a valid/ready port.
//
// Optional feature macro: FSM_MON_STUCK_EN
//   When defined, a counter measures how long the FSM has stayed in one state.
//   The sticky stuck flag rises once the state has held for STUCK_LIMIT cycles.
//   When undefined, stuck is tied to 0.
//
// Ports:
//   clk          in   clock, all logic on the rising edge
//   rst_n        in   synchronous active-low reset
//   state_in     in   observed FSM state
//   out_in       in   observed FSM output
//   mon_en       in   monitoring enable (prev_state sampling continues when 0)
//   rec_valid    out  record FIFO is non-empty
//   rec_ready    in   consumer accepts the head record
//   rec_from     out  head record: previous state
//   rec_to       out  head record: new state
//   rec_out      out  head record: out_in at the change
//   rec_ts       out  head record: cycle timestamp
//   trans_count  out  saturating count of detected transitions
//   visited      out  sticky bitmap of states seen while monitoring
//   illegal      out  sticky: a state outside LEGAL_MASK was seen
//   overflow     out  sticky: a record was dropped on a full FIFO
//   stuck        out  sticky stuck flag (optional feature)

module fsm_transition_monitor #(
   parameter int                    STATE_W    = 2,
   parameter int                    DEPTH      = 4,
   parameter int                    CNT_W      = 16,
   parameter logic [2**STATE_W-1:0] LEGAL_MASK = 4'b0111
`ifdef FSM_MON_STUCK_EN
   ,
   parameter int                    STUCK_LIMIT = 8
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [STATE_W-1:0]    state_in,
   input  logic                  out_in,
   input  logic                  mon_en,
   output logic                  rec_valid,
   input  logic                  rec_ready,
   output logic [STATE_W-1:0]    rec_from,
   output logic [STATE_W-1:0]    rec_to,
   output logic                  rec_out,
   output logic [CNT_W-1:0]      rec_ts,
   output logic [CNT_W-1:0]      trans_count,
   output logic [2**STATE_W-1:0] visited,
   output logic                  illegal,
   output logic                  overflow,
   output logic                  stuck
);

   localparam int AW = $clog2(DEPTH);

   logic [STATE_W-1:0] prev_state;
   logic               primed;
   logic [CNT_W-1:0]   timestamp;

   logic [STATE_W-1:0] mem_from [DEPTH];
   logic [STATE_W-1:0] mem_to   [DEPTH];
   logic               mem_out  [DEPTH];
   logic [CNT_W-1:0]   mem_ts   [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;

   logic detect;
   logic pop;
   logic full;
   logic do_push;

   // A transition is only meaningful once prev_state holds a real sample.
   // With a full FIFO, a same-cycle pop frees the slot the new record needs.
   assign detect  = primed && mon_en && (state_in != prev_state);
   assign rec_valid = (count != '0);
   assign pop     = rec_valid && rec_ready;
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = detect && (!full || pop);

   assign rec_from = mem_from[rd_ptr];
   assign rec_to   = mem_to[rd_ptr];
   assign rec_out  = mem_out[rd_ptr];
   assign rec_ts   = mem_ts[rd_ptr];

   // Sampling front end. The timestamp runs freely and saturates. prev_state
   // follows state_in every cycle, whether or not monitoring is enabled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_state <= '0;
         primed     <= 1'b0;
         timestamp  <= '0;
      end else begin
         prev_state <= state_in;
         primed     <= 1'b1;
         if (timestamp != '1) begin
            timestamp <= timestamp + CNT_W'(1);
         end
      end
   end

   // Sticky statistics and the transition counter. An illegal state still
   // counts as a visit and still produces a record, so nothing is lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trans_count <= '0;
         visited     <= '0;
         illegal     <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (mon_en) begin
            visited[state_in] <= 1'b1;
            if (!LEGAL_MASK[state_in]) begin
               illegal <= 1'b1;
            end
         end
         if (detect) begin
            if (trans_count != '1) begin
               trans_count <= trans_count + CNT_W'(1);
            end
            if (full && !pop) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   // Record FIFO. Storage is registered, so a record pushed on this edge
   // appears on rec_* one cycle later, and an empty FIFO never bypasses.
   // The occupancy is held in its own counter so that full and empty can
   // be told apart when the pointers are equal.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_from[i] <= '0;
            mem_to[i]   <= '0;
            mem_out[i]  <= 1'b0;
            mem_ts[i]   <= '0;
         end
      end else begin
         if (do_push) begin
            mem_from[wr_ptr] <= prev_state;
            mem_to[wr_ptr]   <= state_in;
            mem_out[wr_ptr]  <= out_in;
            mem_ts[wr_ptr]   <= timestamp;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FSM_MON_STUCK_EN
   localparam int SW = $clog2(STUCK_LIMIT + 1);

   logic [SW-1:0] stuck_cnt;
   logic          stuck_q;

   // Stuck detector. It counts consecutive monitored cycles with no state
   // change and saturates at the limit. The flag rises on the edge where the
   // count reaches STUCK_LIMIT and stays set until reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stuck_cnt <= '0;
         stuck_q   <= 1'b0;
      end else if (primed && mon_en && (state_in == prev_state)) begin
         if (stuck_cnt != SW'(STUCK_LIMIT)) begin
            stuck_cnt <= stuck_cnt + SW'(1);
         end
         if (stuck_cnt >= SW'(STUCK_LIMIT - 1)) begin
            stuck_q <= 1'b1;
         end
      end else begin
         stuck_cnt <= '0;
      end
   end

   assign stuck = stuck_q;
`else
   assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_transition_monitor.sv
// tb_fsm_transition_monitor
// Directed bench for fsm_transition_monitor. A behavioural model runs beside
// the DUT and pushes each expected record into a scoreboard queue. Records are
// compared at the queue head whenever the DUT presents one.

module tb_fsm_transition_monitor;

   localparam int STATE_W = 2;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = 16;
   localparam int LIMIT   = 8;
`ifdef FSM_MON_STUCK_EN
   localparam bit STUCK_ON = 1'b1;
`else
   localparam bit STUCK_ON = 1'b0;
`endif

   typedef struct {
      logic [STATE_W-1:0] from;
      logic [STATE_W-1:0] to;
      logic               out;
      logic [CNT_W-1:0]   ts;
   } rec_t;

   logic               clk;
   logic               rst_n;
   logic [STATE_W-1:0] state_in;
   logic               out_in;
   logic               mon_en;
   logic               rec_valid;
   logic               rec_ready;
   logic [STATE_W-1:0] rec_from;
   logic [STATE_W-1:0] rec_to;
   logic               rec_out;
   logic [CNT_W-1:0]   rec_ts;
   logic [CNT_W-1:0]   trans_count;
   logic [3:0]         visited;
   logic               illegal;
   logic               overflow;
   logic               stuck;

   int checks   = 0;
   int failures = 0;

   rec_t               exp_q[$];
   logic               m_primed;
   logic [STATE_W-1:0] m_prev;
   logic [CNT_W-1:0]   m_ts;
   logic [CNT_W-1:0]   m_tc;
   logic [3:0]         m_visited;
   logic               m_illegal;
   logic               m_overflow;
   int                 m_scnt;
   logic               m_stuck;

   logic [STATE_W-1:0] cur_state;
   logic               cur_en;
   logic [CNT_W-1:0]   saved_tc;

   fsm_transition_monitor dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .state_in    (state_in),
      .out_in      (out_in),
      .mon_en      (mon_en),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_from    (rec_from),
      .rec_to      (rec_to),
      .rec_out     (rec_out),
      .rec_ts      (rec_ts),
      .trans_count (trans_count),
      .visited     (visited),
      .illegal     (illegal),
      .overflow    (overflow),
      .stuck       (stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model. It is updated on each rising edge from the inputs the
   // bench is driving, and it never reads DUT outputs.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_primed   = 1'b0;
         m_prev     = '0;
         m_ts       = '0;
         m_tc       = '0;
         m_visited  = '0;
         m_illegal  = 1'b0;
         m_overflow = 1'b0;
         m_scnt     = 0;
         m_stuck    = 1'b0;
      end else begin
         if (exp_q.size() != 0 && rec_ready) begin
            void'(exp_q.pop_front());
         end
         if (m_primed && mon_en && state_in != m_prev) begin
            if (exp_q.size() < DEPTH) begin
               exp_q.push_back('{from: m_prev, to: state_in, out: out_in, ts: m_ts});
            end else begin
               m_overflow = 1'b1;
            end
            if (m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
         end
         if (m_primed && mon_en && state_in == m_prev) begin
            if (m_scnt < LIMIT) m_scnt++;
            if (m_scnt >= LIMIT && STUCK_ON) m_stuck = 1'b1;
         end else begin
            m_scnt = 0;
         end
         if (mon_en) begin
            m_visited[state_in] = 1'b1;
            if (state_in == 2'd3) m_illegal = 1'b1;
         end
         m_prev   = state_in;
         m_primed = 1'b1;
         if (m_ts != 16'hFFFF) m_ts = m_ts + 16'd1;
      end
   end

   // Drive one cycle of inputs, then wait until 1 time unit after the edge
   // that samples them, when both DUT and model have settled.
   task automatic applyStimulus(input logic r, input logic [STATE_W-1:0] st,
                                input logic o, input logic en, input logic rdy);
      rst_n     = r;
      state_in  = st;
      out_in    = o;
      mon_en    = en;
      rec_ready = rdy;
      cur_state = st;
      cur_en    = en;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Compare the DUT head record against the scoreboard head.
   task automatic checkHead(input string tag);
      checkOutput({tag, ".valid"}, rec_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         checkOutput({tag, ".from"}, rec_from, exp_q[0].from);
         checkOutput({tag, ".to"},   rec_to,   exp_q[0].to);
         checkOutput({tag, ".out"},  rec_out,  exp_q[0].out);
         checkOutput({tag, ".ts"},   rec_ts,   exp_q[0].ts);
      end
   endtask

   task automatic drainOne(input string tag);
      checkHead(tag);
      applyStimulus(1'b1, cur_state, 1'b0, cur_en, 1'b1);
      rec_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; state_in = '0; out_in = 1'b0; mon_en = 1'b0; rec_ready = 1'b0;
      cur_state = '0; cur_en = 1'b0;

      // Reset, then idle in state 0
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("rst.valid",   rec_valid,   0);
      checkOutput("rst.tc",      trans_count, 0);
      checkOutput("rst.visited", visited,     0);
      checkOutput("rst.flags",   {illegal, overflow, stuck}, 0);
      checkOutput("rst.head",    {rec_from, rec_to, rec_out, rec_ts}, 0);
      repeat (3) applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("idle.valid",   rec_valid,   0);
      checkOutput("idle.tc",      trans_count, m_tc);
      checkOutput("idle.visited", visited,     4'b0001);
      checkOutput("idle.illegal", illegal,     0);

      // Single transition 0->2, head held until rec_ready pulses
      applyStimulus(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
      checkHead("single");
      checkOutput("single.ts3", rec_ts, 3);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
         checkHead("hold");
      end
      drainOne("single.pop");
      checkOutput("single.empty", rec_valid, 0);

      // Overflow: 2->0 drained, then five toggles into a 4-entry FIFO
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
      drainOne("ovf.pre");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 2'd1 : 2'd0, i[0], 1'b1, 1'b0);
      end
      checkOutput("ovf.flag", overflow,    1);
      checkOutput("ovf.tc",   trans_count, m_tc);
      checkOutput("ovf.qlen", exp_q.size(), DEPTH);
      for (int i = 0; i < DEPTH; i++) drainOne("ovf.drain");
      checkOutput("ovf.empty", rec_valid, 0);

      // Reset while two records are queued
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
      checkOutput("mid.valid", rec_valid, 1);
      applyStimulus(1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
      checkOutput("mid.valid0", rec_valid,   0);
      checkOutput("mid.tc",     trans_count, 0);
      checkOutput("mid.visited", visited,    0);
      checkOutput("mid.flags",  {illegal, overflow, stuck}, 0);

      // Full FIFO with simultaneous push and pop
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 2'd1 : 2'd0, 1'b1, 1'b1, 1'b0);
      end
      checkHead("full.head");
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b1);
      rec_ready = 1'b0;
      checkOutput("full.ovf", overflow, 0);
      for (int i = 0; i < DEPTH; i++) drainOne("full.drain");
      checkOutput("full.empty", rec_valid, 0);

      // Push with rec_ready high on an empty FIFO: no bypass
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b1);
      checkOutput("nobypass.valid", rec_valid, 1);
      drainOne("nobypass");

      // Illegal state, then mon_en low
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
      checkOutput("ill.flag", illegal, 1);
      checkOutput("ill.v3",   visited[3], 1);
      checkOutput("ill.visited", visited, m_visited);
      drainOne("ill.rec");
      saved_tc = m_tc;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 2'd0 : 2'd1, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("off.valid", rec_valid,   0);
      checkOutput("off.tc",    trans_count, saved_tc);

      // Hold state 1 with monitoring on
      for (int i = 0; i < LIMIT - 1; i++) applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
      checkOutput("stuck.before", stuck, 0);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
      checkOutput("stuck.after", stuck, STUCK_ON);
      checkOutput("stuck.model", stuck, m_stuck);
      checkOutput("final.tc",    trans_count, m_tc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
